// File: rtl/top_level.sv
// Half-precision adder; FLT_SUB_EN enables signed subtraction. Operands come from DM1.Core[8..11]; result goes to Core[12..13].
// Return rises 10 edges after Start is sampled, on the Core[13] write. It then holds until Reset; there is no backpressure.

module data_mem (
  input  logic       Clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] Core [0:255];

  assign rdata = Core[addr];

  always_ff @(posedge Clk) begin
    if (we) Core[addr] <= wdata;
  end
endmodule

module top_level (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Return
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    ALIGN = 3'd2,
    ADD   = 3'd3,
    NORM  = 3'd4,
    WR_LO = 3'd5,
    WR_HI = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [15:0] a_reg;
  logic [14:0] b_reg;
  logic [10:0] big_m, sm_m, norm_m;
  logic [5:0]  exp_r, norm_e;
  logic [11:0] sum_r;
  logic        sign_r, sub_op, norm_step, zero_r, uflow_r;
  logic [15:0] res_r;
`ifdef FLT_SUB_EN
  logic        b_sign;
  logic [3:0]  lz;
`endif

  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, rd_data;

  data_mem DM1 (
    .Clk   (Clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rd_data)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 8'd8 + {6'd0, cnt};
    mem_wdata = res_r[7:0];
    if (state == WR_LO) begin
      mem_we   = 1'b1;
      mem_addr = 8'd12;
    end else if (state == WR_HI) begin
      mem_we    = 1'b1;
      mem_addr  = 8'd13;
      mem_wdata = res_r[15:8];
    end
  end

  logic [4:0]  ea, eb, ediff;
  logic [10:0] ma, mb, sm_raw, sm_shift;
  logic        a_big;

  always_comb begin
    ea       = a_reg[14:10];
    eb       = b_reg[14:10];
    ma       = {|ea, a_reg[9:0]};
    mb       = {|eb, b_reg[9:0]};
    a_big    = (ea >= eb);
    ediff    = a_big ? (ea - eb) : (eb - ea);
    sm_raw   = a_big ? mb : ma;
    // Truncating alignment: bits shifted past the LSB are simply lost.
    sm_shift = (ediff >= 5'd11) ? 11'd0 : (sm_raw >> ediff);
  end

`ifdef FLT_SUB_EN
  always_comb begin
    lz = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (sum_r[i]) lz = 4'(10 - i);
    end
  end
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      Return    <= 1'b0;
      cnt       <= 2'd0;
      a_reg     <= 16'd0;
      b_reg     <= 15'd0;
      big_m     <= 11'd0;
      sm_m      <= 11'd0;
      norm_m    <= 11'd0;
      exp_r     <= 6'd0;
      norm_e    <= 6'd0;
      sum_r     <= 12'd0;
      sign_r    <= 1'b0;
      sub_op    <= 1'b0;
      norm_step <= 1'b0;
      zero_r    <= 1'b0;
      uflow_r   <= 1'b0;
      res_r     <= 16'd0;
`ifdef FLT_SUB_EN
      b_sign    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state <= RD;
            cnt   <= 2'd0;
          end
        end
        RD: begin
          case (cnt)
            2'd0: a_reg[7:0]  <= rd_data;
            2'd1: a_reg[15:8] <= rd_data;
            2'd2: b_reg[7:0]  <= rd_data;
            2'd3: begin
              b_reg[14:8] <= rd_data[6:0];
`ifdef FLT_SUB_EN
              b_sign      <= rd_data[7];
`endif
            end
          endcase
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= ALIGN;
        end
        ALIGN: begin
          big_m <= a_big ? ma : mb;
          sm_m  <= sm_shift;
          exp_r <= {1'b0, (a_big ? ea : eb)};
`ifdef FLT_SUB_EN
          sub_op <= a_reg[15] ^ b_sign;
          sign_r <= ((a_reg[15] ^ b_sign) && (b_reg > a_reg[14:0])) ? b_sign : a_reg[15];
`else
          sub_op <= 1'b0;
          sign_r <= a_reg[15];
`endif
          state <= ADD;
        end
        ADD: begin
          if (sub_op)
            sum_r <= (big_m >= sm_m) ? {1'b0, big_m - sm_m} : {1'b0, sm_m - big_m};
          else
            sum_r <= {1'b0, big_m} + {1'b0, sm_m};
          norm_step <= 1'b0;
          state     <= NORM;
        end
        NORM: begin
          if (!norm_step) begin
            zero_r  <= 1'b0;
            uflow_r <= 1'b0;
            norm_m  <= sum_r[10:0];
            norm_e  <= exp_r;
            if (sum_r[11]) begin
              norm_m <= sum_r[11:1];
              norm_e <= exp_r + 6'd1;
            end
`ifdef FLT_SUB_EN
            else if (sub_op) begin
              if (sum_r == 12'd0)
                zero_r <= 1'b1;
              else if (exp_r <= {2'd0, lz})
                uflow_r <= 1'b1;
              else begin
                norm_m <= sum_r[10:0] << lz;
                norm_e <= exp_r - {2'd0, lz};
              end
            end
`endif
            norm_step <= 1'b1;
          end else begin
            // Second NORM cycle packs the result: zero/underflow flush first, then saturation.
            if (zero_r)
              res_r <= 16'h0000;
            else if (uflow_r)
              res_r <= {sign_r, 15'd0};
            else if (norm_e >= 6'd31)
              res_r <= {sign_r, 5'h1f, 10'd0};
            else
              res_r <= {sign_r, norm_e[4:0], norm_m[9:0]};
            state <= WR_LO;
          end
        end
        WR_LO: state <= WR_HI;
        WR_HI: begin
          state  <= DONE;
          Return <= 1'b1;
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: hand-computed binary16 sums, latency, DONE hold and mid-operation reset.
module tb_top_level;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Start = 1'b0;
  logic Return;
  int   n_checks = 0;
  int   n_errors = 0;

  top_level dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Return (Return)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b);
    dut.DM1.Core[8]  <= a[7:0];
    dut.DM1.Core[9]  <= a[15:8];
    dut.DM1.Core[10] <= b[7:0];
    dut.DM1.Core[11] <= b[15:8];
    dut.DM1.Core[12] <= 8'hAA;
    dut.DM1.Core[13] <= 8'hAA;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
    Reset = 1'b0;
    load(a, b);
    #2;
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    check({tag, "_lo_pre"}, {8'h00, dut.DM1.Core[12]}, 16'h00AA);
    @(posedge Clk);
    #1;
    check({tag, "_lo"},     {8'h00, dut.DM1.Core[12]}, {8'h00, exp[7:0]});
    check({tag, "_hi_pre"}, {8'h00, dut.DM1.Core[13]}, 16'h00AA);
    check({tag, "_ret_pre"}, {15'd0, Return}, 16'd0);
    @(posedge Clk);
    #1;
    check({tag, "_ret"},    {15'd0, Return}, 16'd1);
    check({tag, "_res"},    {dut.DM1.Core[13], dut.DM1.Core[12]}, exp);
  endtask

  localparam int NV = 7;
  logic [15:0] va [NV] = '{16'h1A04, 16'h4A10, 16'h4200, 16'h7A04, 16'h4600, 16'h4200, 16'h5800};
  logic [15:0] vb [NV] = '{16'h1A04, 16'h4204, 16'h5604, 16'h7A04, 16'hC200, 16'hC200, 16'h2C00};
`ifdef FLT_SUB_EN
  logic [15:0] vr [NV] = '{16'h1E04, 16'h4B91, 16'h5634, 16'h7C00, 16'h4200, 16'h0000, 16'h5800};
`else
  logic [15:0] vr [NV] = '{16'h1E04, 16'h4B91, 16'h5634, 16'h7C00, 16'h4880, 16'h4600, 16'h5800};
`endif

  initial begin
    #3;
    check("rst_return", {15'd0, Return}, 16'd0);
    check("rst_state", 16'(dut.state), 16'd0);

    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), va[i], vb[i], vr[i]);
    end

    // DONE must ignore Start and perform no further writes.
    dut.DM1.Core[12] <= 8'h55;
    @(negedge Clk) Start = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("done_ret", {15'd0, Return}, 16'd1);
    check("done_nowr", {8'h00, dut.DM1.Core[12]}, 16'h0055);
    check("done_state", 16'(dut.state), 16'd7);
    Start = 1'b0;

    // Reset while in ADD aborts the operation without writes.
    Reset = 1'b0;
    load(16'h1A04, 16'h1A04);
    #2;
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    check("mid_in_add", 16'(dut.state), 16'd3);
    Reset = 1'b0;
    #1;
    check("mid_ret", {15'd0, Return}, 16'd0);
    check("mid_state", 16'(dut.state), 16'd0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    check("mid_nowr", {dut.DM1.Core[13], dut.DM1.Core[12]}, 16'hAAAA);
    check("mid_idle_ret", {15'd0, Return}, 16'd0);
    check("mid_idle_state", 16'(dut.state), 16'd0);

    run_op("after_rst", 16'h4A10, 16'h4204, 16'h4B91);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
